fp_align_add: RTL and testbench
===============================

FP_ALIGN_ADD -- requirements
Module: fp_align_add

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  in  1  operand pair valid.
REQ-004 in_ready  out  1  block can accept an operand pair.
REQ-005 a, b  in  32 each  IEEE-754 single operands, computing a+b.
REQ-006 out_valid  out  1  result valid; feeds the normalize stage.
REQ-007 out_ready  in  1  downstream accepts result.
REQ-008 mant_out  out  29  unnormalized magnitude: bit28 carry, bit27 hidden, 26:4 fraction, 3:1 guard, 0 sticky.
REQ-009 exp_out  out  8  exponent of the larger operand.
REQ-010 sign_out  out  1  result sign.

Function
REQ-011 Unpack: ext = {0, hidden, frac[22:0], 4'b0}; hidden = (exp != 0); exp==0 treated as zero/denormal-flushed; inf/NaN not special-cased.
REQ-012 Accept on rising edge with in_valid && in_ready; in_ready = 1 only in IDLE.
REQ-013 Swap at accept: larger = higher exp; tie → higher ext mantissa; full tie → a.
REQ-014 Shift count = min(exp_large − exp_small, 28), latched at accept.
REQ-015 States: IDLE, ALIGN, ADD, DONE.
REQ-016 IDLE→ALIGN on accept if count>0, else IDLE→ADD.
REQ-017 ALIGN: each cycle small = {0, small[28:1]}, new bit0 = small[1] | small[0]; count−1; →ADD when count reaches 0.
REQ-018 ADD (one cycle): equal signs → large+small; differing signs → large−small; 29-bit result, no overflow beyond bit28; →DONE.
REQ-019 sign_out = sign of larger operand; exact-zero result from differing signs → sign_out = 0.
REQ-020 DONE: out_valid = 1; mant_out/exp_out/sign_out held stable until out_valid && out_ready; then →IDLE.
REQ-021 Latency: out_valid rises count+2 rising edges after the accept edge (accept edge counted as edge 1).
REQ-022 Outputs hold their last value outside DONE; they are don't-care while out_valid = 0.
REQ-023 in_valid while busy is ignored, not queued; a and b are sampled only at the accept edge.

Reset
REQ-024 rst_n low → state IDLE immediately; out_valid = 0, mant_out = 0, exp_out = 0, sign_out = 0, count = 0.
REQ-025 rst_n low mid-ALIGN/ADD/DONE aborts the operation; no output is produced for it.
REQ-026 First accept possible on the first rising edge after rst_n deasserts.

Structure
REQ-027 Shared package fp_pkg: MANT_W = 29, EXP_W = 8, FRAC_W = 23, bit-position constants (CARRY = 28, HIDDEN = 27, STICKY = 0), MAX_SHIFT = 28, state enum.
REQ-028 One sub-module fp_unpack: 32-bit float → sign, exp, 29-bit ext mantissa; instantiated twice.
REQ-029 Target size is 120-400 RTL lines, with a single FSM and one adder/subtractor.

Verification
REQ-030 a = 0x3F800000, b = 0x3F800000 → mant_out = 0x10000000, exp_out = 0x7F, sign_out = 0, out_valid on edge 2.
REQ-031 a = 0x3F800000, b = 0x3F000000 → one ALIGN cycle; mant_out = 0x0C000000, exp_out = 0x7F, out_valid on edge 3.
REQ-032 a = 0x3F000000, b = 0xBF800000 → swap; mant_out = 0x04000000, exp_out = 0x7F, sign_out = 1; a = 0x3F800000, b = 0xBF800000 → mant_out = 0, sign_out = 0.
REQ-033 a = 0x7F000000, b = 0x3F800000 → count clamped to 28; mant_out = 0x08000001 (sticky), exp_out = 0xFE, out_valid on edge 30; a = 0x4B800000, b = 0x3F800000 → mant_out = 0x08000008, out_valid on edge 26.
REQ-034 Hold out_ready = 0 for 5 cycles in DONE → outputs stable, in_ready = 0, extra in_valid ignored; assert rst_n low mid-ALIGN → out_valid = 0, IDLE, in_ready = 1 after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, FSM state type and mantissa helpers for the
// floating-point alignment/add stage.
package fp_pkg;

  localparam int MANT_W    = 29;
  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int CARRY     = 28;
  localparam int HIDDEN    = 27;
  localparam int STICKY    = 0;
  localparam int MAX_SHIFT = 28;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Exponent differences beyond MAX_SHIFT collapse the small operand into
  // sticky anyway, so the alignment loop never runs longer than that.
  function automatic logic [CNT_W-1:0] clamp_shift(input logic [EXP_W-1:0] diff);
    logic [CNT_W-1:0] cnt;
    if (diff > 8'(MAX_SHIFT)) begin
      cnt = 5'(MAX_SHIFT);
    end else begin
      cnt = diff[CNT_W-1:0];
    end
    return cnt;
  endfunction

  // One-bit right shift that ORs the two lowest bits into the sticky slot.
  function automatic logic [MANT_W-1:0] sticky_shr(input logic [MANT_W-1:0] m);
    return {1'b0, m[MANT_W-1:2], m[1] | m[STICKY]};
  endfunction

endpackage

// File: rtl/fp_align_add_if.sv
// Operand/result handshake bundle between the producer and the align/add stage.
interface fp_align_add_if;
  import fp_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [31:0]         a;
  logic [31:0]         b;
  logic                out_valid;
  logic                out_ready;
  logic [MANT_W-1:0]   mant_out;
  logic [EXP_W-1:0]    exp_out;
  logic                sign_out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, mant_out, exp_out, sign_out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, mant_out, exp_out, sign_out
  );

endinterface

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 single into sign, exponent and the 29-bit extended
// mantissa; zero exponents flush to a zero hidden bit.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       value,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] mant
);

  logic hidden_s;

  assign sign     = value[31];
  assign exp      = value[30:FRAC_W];
  assign hidden_s = |value[30:FRAC_W];
  assign mant     = {1'b0, hidden_s, value[FRAC_W-1:0], 4'b0000};

endmodule

// File: rtl/fp_align_add.sv
// Aligns the smaller operand one bit per cycle (with sticky) and produces the
// unnormalized sum/difference for the downstream normalize stage.
module fp_align_add
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  fp_align_add_if.slave bus
);

  state_t state_r, next_state_s;

  logic              sign_a_s, sign_b_s;
  logic [EXP_W-1:0]  exp_a_s, exp_b_s;
  logic [MANT_W-1:0] mant_a_s, mant_b_s;

  logic              a_larger_s;
  logic [EXP_W-1:0]  exp_diff_s;
  logic [CNT_W-1:0]  shift_s;
  logic              in_ready_s;
  logic              accept_s;
  logic [MANT_W-1:0] result_s;

  logic [MANT_W-1:0] large_r, small_r;
  logic [EXP_W-1:0]  exp_r;
  logic              sign_r;
  logic              eff_sub_r;
  logic [CNT_W-1:0]  count_r;

  logic [MANT_W-1:0] mant_out_r;
  logic [EXP_W-1:0]  exp_out_r;
  logic              sign_out_r;
  logic              out_valid_r;

  fp_unpack u_unpack_a (.value(bus.a), .sign(sign_a_s), .exp(exp_a_s), .mant(mant_a_s));
  fp_unpack u_unpack_b (.value(bus.b), .sign(sign_b_s), .exp(exp_b_s), .mant(mant_b_s));

  // A full tie (same exponent and mantissa) keeps a as the larger operand.
  assign a_larger_s = (exp_a_s > exp_b_s) ||
                      ((exp_a_s == exp_b_s) && (mant_a_s >= mant_b_s));
  assign exp_diff_s = a_larger_s ? (exp_a_s - exp_b_s) : (exp_b_s - exp_a_s);
  assign shift_s    = clamp_shift(exp_diff_s);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign result_s   = eff_sub_r ? (large_r - small_r) : (large_r + small_r);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.mant_out  = mant_out_r;
  assign bus.exp_out   = exp_out_r;
  assign bus.sign_out  = sign_out_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = (shift_s != {CNT_W{1'b0}}) ? ST_ALIGN : ST_ADD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (count_r <= 5'd1) begin
          next_state_s = ST_ADD;
        end else begin
          next_state_s = ST_ALIGN;
        end
      end
      ST_ADD: begin
        next_state_s = ST_DONE;
      end
      ST_DONE: begin
        if (out_valid_r && bus.out_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM output decode.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE:  in_ready_s = 1'b1;
      ST_ALIGN: in_ready_s = 1'b0;
      ST_ADD:   in_ready_s = 1'b0;
      ST_DONE:  in_ready_s = 1'b0;
      default:  in_ready_s = 1'b0;
    endcase
  end

  // Operand capture, alignment shifting and the add/subtract result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      large_r     <= {MANT_W{1'b0}};
      small_r     <= {MANT_W{1'b0}};
      exp_r       <= {EXP_W{1'b0}};
      sign_r      <= 1'b0;
      eff_sub_r   <= 1'b0;
      count_r     <= {CNT_W{1'b0}};
      mant_out_r  <= {MANT_W{1'b0}};
      exp_out_r   <= {EXP_W{1'b0}};
      sign_out_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            large_r   <= a_larger_s ? mant_a_s : mant_b_s;
            small_r   <= a_larger_s ? mant_b_s : mant_a_s;
            exp_r     <= a_larger_s ? exp_a_s  : exp_b_s;
            sign_r    <= a_larger_s ? sign_a_s : sign_b_s;
            eff_sub_r <= sign_a_s ^ sign_b_s;
            count_r   <= shift_s;
          end
        end
        ST_ALIGN: begin
          small_r <= sticky_shr(small_r);
          count_r <= count_r - 5'd1;
        end
        ST_ADD: begin
          mant_out_r  <= result_s;
          exp_out_r   <= exp_r;
          // Exact cancellation always yields +0.
          sign_out_r  <= (eff_sub_r && (result_s == {MANT_W{1'b0}})) ? 1'b0 : sign_r;
          out_valid_r <= 1'b1;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
// Directed-vector bench for fp_align_add: table of operand pairs with
// hand-derived results and latencies, plus backpressure and reset sequences.
module tb_fp_align_add;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  fp_align_add_if bus ();

  fp_align_add dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [28:0] mant;
    logic [7:0]  exp;
    logic        sign;
    int          lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, output int lat);
    @(negedge clk);
    bus.a        = op_a;
    bus.b        = op_b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;

    tests = 0;
    fails = 0;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 29'h10000000, 8'h7F, 1'b0, 2};
    vecs[1]  = '{32'h3F800000, 32'h3F000000, 29'h0C000000, 8'h7F, 1'b0, 3};
    vecs[2]  = '{32'h3F000000, 32'hBF800000, 29'h04000000, 8'h7F, 1'b1, 3};
    vecs[3]  = '{32'h3F800000, 32'hBF800000, 29'h00000000, 8'h7F, 1'b0, 2};
    vecs[4]  = '{32'h7F000000, 32'h3F800000, 29'h08000001, 8'hFE, 1'b0, 30};
    vecs[5]  = '{32'h4B800000, 32'h3F800000, 29'h08000008, 8'h97, 1'b0, 26};
    vecs[6]  = '{32'h00000000, 32'h00000000, 29'h00000000, 8'h00, 1'b0, 2};
    vecs[7]  = '{32'hC0000000, 32'hC0000000, 29'h10000000, 8'h80, 1'b1, 2};
    vecs[8]  = '{32'h40400000, 32'h3F800000, 29'h10000000, 8'h80, 1'b0, 3};
    vecs[9]  = '{32'hBF800000, 32'h3FC00000, 29'h04000000, 8'h7F, 1'b0, 2};
    vecs[10] = '{32'h00000001, 32'h3F800000, 29'h08000001, 8'h7F, 1'b0, 30};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_mant", {3'd0, bus.mant_out}, 32'd0);
    check("rst_exp", {24'd0, bus.exp_out}, 32'd0);
    check("rst_sign", {31'd0, bus.sign_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      check($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      run_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_mant", i), {3'd0, bus.mant_out}, {3'd0, vecs[i].mant});
      check($sformatf("v%0d_exp", i), {24'd0, bus.exp_out}, {24'd0, vecs[i].exp});
      check($sformatf("v%0d_sign", i), {31'd0, bus.sign_out}, {31'd0, vecs[i].sign});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_released", i), {31'd0, bus.out_valid}, 32'd0);
    end

    // Backpressure in DONE: outputs hold, new requests are ignored.
    bus.out_ready = 1'b0;
    run_op(32'h3F800000, 32'h3F000000, lat);
    check("bp_latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 32'h40000000;
      bus.b        = 32'h40000000;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_out_valid", k), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("bp%0d_in_ready", k), {31'd0, bus.in_ready}, 32'd0);
      check($sformatf("bp%0d_mant", k), {3'd0, bus.mant_out}, 32'h0C000000);
      check($sformatf("bp%0d_exp", k), {24'd0, bus.exp_out}, 32'h7F);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_drain_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_drain_ready", {31'd0, bus.in_ready}, 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("bp_not_queued", {31'd0, seen}, 32'd0);

    // Reset in the middle of a long alignment aborts the operation.
    @(negedge clk);
    bus.a        = 32'h7F000000;
    bus.b        = 32'h3F800000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_align_busy", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_mant", {3'd0, bus.mant_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("abort_no_output", {31'd0, seen}, 32'd0);

    // Accept on the very first edge after reset release.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n        = 1'b1;
    bus.a        = 32'h3F800000;
    bus.b        = 32'h3F800000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("first_edge_valid", {31'd0, bus.out_valid}, 32'd1);
    check("first_edge_mant", {3'd0, bus.mant_out}, 32'h10000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
